// File: rtl/tage_hist_buffer.sv
// TAGE global/path history: circular outcome buffer with a head pointer and
// a path register, both exported as checkpoints for mispredict repair.
// config_pkg is kept minimal so this file stands alone. It carries only the
// history fields this block reads.
package config_pkg;
   typedef struct packed {
      int unsigned       histBufferBits;
      logic [3:0][31:0]  histLengths;
      int unsigned       pathHistBits;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{
      histBufferBits: 64,
      histLengths:    {32'd4, 32'd8, 32'd16, 32'd32},
      pathHistBits:   16
   };
endpackage

module tage_hist_buffer #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter int HistBufBits = int'(CVA6Cfg.histBufferBits),
   parameter int MaxHist     = int'(CVA6Cfg.histLengths[0]),
   parameter int PathBits    = int'(CVA6Cfg.pathHistBits),
   localparam int PtrW       = $clog2(HistBufBits)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                spec_valid_i,
   input  logic                spec_taken_i,
   input  logic                spec_pc_bit_i,
   input  logic                recover_valid_i,
   input  logic [PtrW-1:0]     recover_ptr_i,
   input  logic [PathBits-1:0] recover_path_i,
   input  logic                recover_taken_i,
   input  logic                recover_pc_bit_i,
   output logic [PtrW-1:0]     ptr_o,
   output logic [PathBits-1:0] path_o,
   output logic [MaxHist-1:0]  ghist_o
);

   if ((HistBufBits & (HistBufBits - 1)) != 0 || HistBufBits < 2 * MaxHist
       || PathBits < 2) begin : g_cfg_chk
      $error("tage_hist_buffer: HistBufBits must be a power of two >= 2*MaxHist");
   end

   logic [HistBufBits-1:0] buf_q;
   logic [PtrW-1:0]        ptr_q;
   logic [PathBits-1:0]    path_q;

   // The buffer grows toward lower indices, so the newest outcome always sits at ptr_q.
   logic [PtrW-1:0] spec_idx, rec_idx;
   assign spec_idx = ptr_q - PtrW'(1);
   assign rec_idx  = recover_ptr_i - PtrW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_q  <= '0;
         ptr_q  <= '0;
         path_q <= '0;
      end else if (flush_i) begin
         buf_q  <= '0;
         ptr_q  <= '0;
         path_q <= '0;
      end else if (recover_valid_i) begin
         // Only the head entry is rewritten. Older entries still hold the
         // history that was live at the checkpoint.
         buf_q[rec_idx] <= recover_taken_i;
         ptr_q          <= rec_idx;
         path_q         <= {recover_path_i[PathBits-2:0], recover_pc_bit_i};
      end else if (spec_valid_i) begin
         buf_q[spec_idx] <= spec_taken_i;
         ptr_q           <= spec_idx;
         path_q          <= {path_q[PathBits-2:0], spec_pc_bit_i};
      end
   end

   for (genvar i = 0; i < MaxHist; i++) begin : g_win
      assign ghist_o[i] = buf_q[ptr_q + PtrW'(i)];
   end

   assign ptr_o  = ptr_q;
   assign path_o = path_q;

   logic unused_msb;
   assign unused_msb = ^{recover_path_i[PathBits-1], path_q[PathBits-1]};

endmodule

// File: tb/tb_tage_hist_buffer.sv
// Directed-vector bench for tage_hist_buffer using a 16-bit buffer, an 8-bit window and an 8-bit path.
module tb_tage_hist_buffer;
   localparam int HB = 16;
   localparam int MH = 8;
   localparam int PB = 8;
   localparam int PW = $clog2(HB);

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic          spec_valid_i = 1'b0, spec_taken_i = 1'b0, spec_pc_bit_i = 1'b0;
   logic          recover_valid_i = 1'b0, recover_taken_i = 1'b0, recover_pc_bit_i = 1'b0;
   logic [PW-1:0] recover_ptr_i = '0;
   logic [PB-1:0] recover_path_i = '0;
   logic [PW-1:0] ptr_o;
   logic [PB-1:0] path_o;
   logic [MH-1:0] ghist_o;

   int nvec = 0;
   int nerr = 0;

   tage_hist_buffer #(
      .HistBufBits(HB), .MaxHist(MH), .PathBits(PB)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
      .spec_valid_i(spec_valid_i), .spec_taken_i(spec_taken_i), .spec_pc_bit_i(spec_pc_bit_i),
      .recover_valid_i(recover_valid_i), .recover_ptr_i(recover_ptr_i),
      .recover_path_i(recover_path_i), .recover_taken_i(recover_taken_i),
      .recover_pc_bit_i(recover_pc_bit_i),
      .ptr_o(ptr_o), .path_o(path_o), .ghist_o(ghist_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [PW-1:0] p,
                          input logic [PB-1:0] q, input logic [MH-1:0] g);
      chk({tag, ".ptr"},   32'(ptr_o),   32'(p));
      chk({tag, ".path"},  32'(path_o),  32'(q));
      chk({tag, ".ghist"}, 32'(ghist_o), 32'(g));
   endtask

   // Called at a negedge. The update lands on the following posedge.
   task automatic push(input logic t, input logic pc);
      spec_valid_i = 1'b1; spec_taken_i = t; spec_pc_bit_i = pc;
      @(negedge clk);
      spec_valid_i = 1'b0;
   endtask

   task automatic recover(input logic [PW-1:0] p, input logic [PB-1:0] q,
                          input logic t, input logic pc);
      recover_valid_i = 1'b1; recover_ptr_i = p; recover_path_i = q;
      recover_taken_i = t; recover_pc_bit_i = pc;
      @(negedge clk);
      recover_valid_i = 1'b0;
   endtask

   initial begin
      // Reset is held across several clock edges.
      repeat (3) @(negedge clk);
      chk_all("reset", 4'd0, 8'h00, 8'h00);
      rst_ni = 1'b1;
      @(negedge clk);

      // Three outcomes are pushed. The newest outcome lands at bit 0.
      push(1'b1, 1'b1); push(1'b0, 1'b1); push(1'b1, 1'b0);
      chk_all("push3", 4'd13, 8'h06, 8'h05);

      // Thirteen more pushes (taken = ~k[0]) bring ptr to 0, giving buf[j] = ~j[0].
      for (int k = 0; k < 13; k++) push(~k[0], 1'b0);
      chk("prewrap.ptr", 32'(ptr_o), 32'd0);
      chk("prewrap.ghist", 32'(ghist_o), 32'h55);

      // A push from ptr 0 wraps the pointer to HB-1.
      push(1'b1, 1'b1);
      chk_all("wrap", 4'd15, 8'h01, 8'hAB);

      // Five pushes land after the checkpoint (P=15, Q=01, window AB).
      for (int k = 0; k < 5; k++) push(1'b0, 1'b1);
      chk_all("spec5", 4'd10, 8'h3F, 8'h60);

      // Recovery to the checkpoint keeps buf[15] and older entries.
      recover(4'd15, 8'h01, 1'b0, 1'b1);
      chk_all("recover", 4'd14, 8'h03, 8'h56);

      // A simultaneous spec push and recovery applies only the recovery.
      spec_valid_i = 1'b1; spec_taken_i = 1'b1; spec_pc_bit_i = 1'b1;
      recover(4'd4, 8'hA5, 1'b1, 1'b0);
      spec_valid_i = 1'b0;
      chk_all("both", 4'd3, 8'h4A, 8'h2B);

      // State holds during an idle cycle.
      @(negedge clk);
      chk_all("hold", 4'd3, 8'h4A, 8'h2B);

      // Flush takes priority over a recovery.
      flush_i = 1'b1;
      recover(4'd9, 8'hFF, 1'b1, 1'b1);
      flush_i = 1'b0;
      chk_all("flush", 4'd0, 8'h00, 8'h00);

      // Asynchronous reset is asserted mid-cycle after 10 pushes.
      for (int k = 0; k < 10; k++) push(1'b1, 1'b1);
      chk("pre_rst.ptr", 32'(ptr_o), 32'd6);
      @(posedge clk);
      #2 rst_ni = 1'b0;
      #1 chk_all("async_rst", 4'd0, 8'h00, 8'h00);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);

      // The first push after reset behaves as if from the initial state.
      push(1'b1, 1'b1);
      chk_all("post_rst", 4'd15, 8'h01, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/tage_hist_buffer.md
TAGE_HIST_BUFFER -- requirements
Module: tage_hist_buffer

Interface
REQ-001 SHALL take parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, the built core configuration.
REQ-002 SHALL take parameter HistBufBits, default CVA6Cfg.histBufferBits (power of two, ≥ 2×MaxHist), the circular buffer depth in bits.
REQ-003 SHALL take parameter MaxHist, default CVA6Cfg.histLengths[0] (longest table history), the width of the exported history window.
REQ-004 SHALL take parameter PathBits, default CVA6Cfg.pathHistBits, the path history width.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port flush_i, input, 1, synchronous clear of all history.
REQ-008 SHALL have port spec_valid_i, input, 1, speculative branch prediction update.
REQ-009 SHALL have port spec_taken_i, input, 1, predicted direction.
REQ-010 SHALL have port spec_pc_bit_i, input, 1, branch PC bit shifted into path history.
REQ-011 SHALL have port recover_valid_i, input, 1, mispredict repair.
REQ-012 SHALL have port recover_ptr_i, input, $clog2(HistBufBits), checkpointed pointer of the mispredicted branch.
REQ-013 SHALL have port recover_path_i, input, PathBits, checkpointed path history.
REQ-014 SHALL have port recover_taken_i, input, 1, resolved direction.
REQ-015 SHALL have port recover_pc_bit_i, input, 1, PC bit of the mispredicted branch.
REQ-016 SHALL have port ptr_o, output, $clog2(HistBufBits), current head pointer (the checkpoint value).
REQ-017 SHALL have port path_o, output, PathBits, current path history (the checkpoint value).
REQ-018 SHALL have port ghist_o, output, MaxHist, global history window; bit 0 holds the newest outcome.

Function
REQ-019 SHALL keep a HistBufBits-bit circular buffer buf_q, a head pointer ptr_q and a path register path_q; all outputs SHALL be driven combinationally from these registers.
REQ-020 SHALL drive ghist_o[i] = buf_q[(ptr_q + i) mod HistBufBits] for i = 0..MaxHist-1.
REQ-021 On a speculative push (spec_valid_i=1, recover_valid_i=0, flush_i=0), SHALL set ptr_q to (ptr_q − 1) mod HistBufBits, write buf_q at the new pointer with spec_taken_i, and set path_q to {path_q[PathBits-2:0], spec_pc_bit_i}.
REQ-022 On a recovery (recover_valid_i=1, flush_i=0), SHALL set ptr_q to (recover_ptr_i − 1) mod HistBufBits, write buf_q at that index with recover_taken_i, and set path_q to {recover_path_i[PathBits-2:0], recover_pc_bit_i}.
REQ-023 Recovery SHALL take priority over a simultaneous spec_valid_i; the speculative update SHALL be dropped.
REQ-024 flush_i SHALL take priority over both updates; it SHALL clear buf_q, ptr_q and path_q to 0 on the next edge.
REQ-025 Every update SHALL be visible on ptr_o, path_o and ghist_o exactly one cycle after the update is applied; there SHALL be no bypass.
REQ-026 Pointer arithmetic SHALL wrap modulo HistBufBits: a decrement from 0 SHALL yield HistBufBits-1.
REQ-027 Buffer entries not written by an update SHALL retain their value; entries older than the recovery point SHALL be preserved across a recovery.
REQ-028 With no update in a cycle, all state SHALL hold.
REQ-029 An elaboration assertion SHALL fail if HistBufBits is not a power of two or HistBufBits < 2×MaxHist.

Reset
REQ-030 While rst_ni=0, buf_q, ptr_q and path_q SHALL be 0, so that ptr_o=0, path_o=0 and ghist_o=0; this SHALL hold regardless of clock activity.
REQ-031 Reset asserted mid-stream SHALL discard all history immediately; the first update after reset release SHALL behave as if from the initial state.

Verification
REQ-032 Reset release, then pushes taken=1,0,1 -> ptr_o = HistBufBits-3, ghist_o[2:0] = 3'b101.
REQ-033 Push 1 with ptr_o=0 -> ptr_o = HistBufBits-1, ghist_o[0]=1, ghist_o[1] equals the old buf_q[0] (wrap-around).
REQ-034 Record ptr_o=P and path_o=Q, push 5 branches, then recover with ptr=P, path=Q, taken=0, pc_bit=1 -> ptr_o = P-1, ghist_o[0]=0, ghist_o[5:1] equal the pre-checkpoint ghist_o[4:0], path_o = {Q[PathBits-2:0],1}.
REQ-035 Assert spec_valid_i and recover_valid_i in the same cycle -> only the recovery is applied; then assert flush_i together with recover_valid_i -> all outputs are 0.
REQ-036 Assert rst_ni=0 between clock edges after 10 pushes -> all outputs are 0 before the next edge.
